register_sync_rx: RTL and testbench

Standalone receive end of the req/rdy/conf/ack four-phase register-transfer handshake. The block runs in a single clock domain. It synchronises `req_i`/`conf_i` from a foreign-domain transmitter and answers with `rdy_o`/`ack_o`. It captures the transmitter's held data word and presents it as `reg_o` with a one-cycle valid strobe. A timeout watchdog returns the block to idle when a transmitter stalls after `rdy_o`.

---
 rtl/register_sync_rx.sv | 118 +++++++++++
 tb/tb_register_sync_rx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_sync_rx.sv
// Receive end of a req/rdy/conf/ack four-phase register transfer from a foreign clock domain.
// Control lines are resynchronised; the held data word is sampled twice and checked for stability.
module register_sync_rx #(
  parameter int                   reg_width        = 16,
  parameter logic [reg_width-1:0] reg_preset       = {reg_width{1'b0}},
  parameter int                   resync_stages    = 3,
  parameter string                check_valid_data = "ON",
  parameter int                   timeout_cycles   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 req_i,
  input  logic                 conf_i,
  input  logic [reg_width-1:0] reg_i,
  output logic                 rdy_o,
  output logic                 ack_o,
  output logic [reg_width-1:0] reg_o,
  output logic                 reg_o_valid,
  output logic                 timeout_o
);

  localparam int          last_stage   = resync_stages - 32'sd1;
  localparam bit          check_on     = (check_valid_data == "ON") && (resync_stages >= 32'sd3);
  localparam bit          watchdog_on  = (timeout_cycles != 32'sd0);
  localparam logic [15:0] timeout_last = watchdog_on ? 16'(timeout_cycles - 32'sd1) : 16'd0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CONF_WAIT  = 2'd1,
    ST_CAP0       = 2'd2,
    ST_ROUND_WAIT = 2'd3
  } state_t;

  state_t                   state_r;
  logic [resync_stages-1:0] req_sync_r;
  logic [resync_stages-1:0] conf_sync_r;
  logic [reg_width-1:0]     cap_r [resync_stages];
  logic [15:0]              wd_cnt_r;
  logic                     req_s;
  logic                     conf_s;
  logic                     data_ok_s;
  logic                     wd_expired_s;

  assign req_s        = req_sync_r[last_stage];
  assign conf_s       = conf_sync_r[last_stage];
  // The two oldest samples must agree, otherwise the word was still settling when captured.
  assign data_ok_s    = !check_on || (cap_r[last_stage] == cap_r[last_stage-1]);
  assign wd_expired_s = watchdog_on && (wd_cnt_r == timeout_last);

  // Synchronisers, capture pipeline and transfer FSM; everything advances on enabled cycles only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      req_sync_r  <= {resync_stages{1'b0}};
      conf_sync_r <= {resync_stages{1'b0}};
      wd_cnt_r    <= 16'd0;
      rdy_o       <= 1'b0;
      ack_o       <= 1'b0;
      reg_o       <= reg_preset;
      reg_o_valid <= 1'b0;
      timeout_o   <= 1'b0;
      for (int k = 32'sd0; k < resync_stages; k++) begin
        cap_r[k] <= reg_preset;
      end
    end else if (clk_en) begin
      req_sync_r  <= {req_sync_r[last_stage-1:0], req_i};
      conf_sync_r <= {conf_sync_r[last_stage-1:0], conf_i};
      for (int k = 32'sd1; k < resync_stages; k++) begin
        cap_r[k] <= cap_r[k-1];
      end
      case (state_r)
        ST_IDLE: begin
          reg_o_valid <= 1'b0;
          timeout_o   <= 1'b0;
          if (req_s) begin
            state_r  <= ST_CONF_WAIT;
            rdy_o    <= 1'b1;
            wd_cnt_r <= 16'd0;
          end
        end
        ST_CONF_WAIT: begin
          if (conf_s) begin
            state_r  <= ST_CAP0;
            rdy_o    <= 1'b0;
            cap_r[0] <= reg_i;
          end else if (wd_expired_s) begin
            state_r   <= ST_IDLE;
            rdy_o     <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
          end
        end
        // conf_s can lead the data settling by a cycle, so take a second sample here.
        ST_CAP0: begin
          state_r  <= ST_ROUND_WAIT;
          ack_o    <= 1'b1;
          cap_r[0] <= reg_i;
        end
        ST_ROUND_WAIT: begin
          if (!conf_s && data_ok_s) begin
            state_r     <= ST_IDLE;
            ack_o       <= 1'b0;
            reg_o       <= cap_r[last_stage];
            reg_o_valid <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rdy_o   <= 1'b0;
          ack_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_sync_rx.sv
// Bench for register_sync_rx: edge-history reference model compared every cycle,
// directed handshake scenarios with hand-computed expectations, then randomised transfers.
module tb_register_sync_rx;

  localparam int          N      = 3;
  localparam int          T      = 8;
  localparam logic [15:0] PRESET = 16'h5A5A;
  localparam int          BOUND  = 400;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        clk_en = 1'b1;
  logic        req_i  = 1'b0;
  logic        conf_i = 1'b0;
  logic [15:0] reg_i  = 16'h0000;
  logic        rdy_o, ack_o, reg_o_valid, timeout_o;
  logic [15:0] reg_o;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int ce_mode = 0;
  bit model_live = 1'b0;

  register_sync_rx #(
    .reg_width(16), .reg_preset(PRESET), .resync_stages(N),
    .check_valid_data("ON"), .timeout_cycles(T)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_i(req_i), .conf_i(conf_i), .reg_i(reg_i),
    .rdy_o(rdy_o), .ack_o(ack_o), .reg_o(reg_o), .reg_o_valid(reg_o_valid), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Histories of what was sampled on each enabled edge since reset; a signal that crosses
  // N flops is just the sample from N edges ago, and a captured word is the newest load.
  bit          rq_h[$];
  bit          cf_h[$];
  logic [15:0] c0_h[$];
  int          phase;  // 0 idle, 1 awaiting confirm, 2 second sample, 3 awaiting round end
  int          wd;
  bit          m_rdy, m_ack, m_val, m_tmo;
  logic [15:0] m_reg;

  function automatic logic [15:0] cap0_after(int i);
    return (i < 0) ? PRESET : c0_h[i];
  endfunction

  task automatic model_reset();
    rq_h.delete(); cf_h.delete(); c0_h.delete();
    phase = 0; wd = 0;
    m_rdy = 1'b0; m_ack = 1'b0; m_val = 1'b0; m_tmo = 1'b0; m_reg = PRESET;
    model_live = 1'b1;
  endtask

  task automatic model_step();
    int e;
    bit rs, cs, load;
    logic [15:0] oldest, second;
    e = rq_h.size();
    rq_h.push_back(req_i);
    cf_h.push_back(conf_i);
    rs = (e >= N) ? rq_h[e-N] : 1'b0;
    cs = (e >= N) ? cf_h[e-N] : 1'b0;
    oldest = cap0_after(e - N);
    second = cap0_after(e - N + 1);
    load = 1'b0;
    if (phase == 0) begin
      m_val = 1'b0; m_tmo = 1'b0;
      if (rs) begin phase = 1; m_rdy = 1'b1; wd = 0; end
    end else if (phase == 1) begin
      if (cs) begin phase = 2; m_rdy = 1'b0; load = 1'b1; end
      else if (wd == T - 1) begin phase = 0; m_rdy = 1'b0; m_tmo = 1'b1; end
      else wd++;
    end else if (phase == 2) begin
      phase = 3; m_ack = 1'b1; load = 1'b1;
    end else begin
      if (!cs && oldest == second) begin
        phase = 0; m_ack = 1'b0; m_reg = oldest; m_val = 1'b1;
      end
    end
    c0_h.push_back(load ? reg_i : cap0_after(e - 1));
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) model_reset();
    else if (clk_en) begin
      model_step();
      en_cnt++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      check("rdy_o", 32'(rdy_o), 32'(m_rdy));
      check("ack_o", 32'(ack_o), 32'(m_ack));
      check("reg_o", 32'(reg_o), 32'(m_reg));
      check("reg_o_valid", 32'(reg_o_valid), 32'(m_val));
      check("timeout_o", 32'(timeout_o), 32'(m_tmo));
      check("rdy_ack_excl", 32'(rdy_o & ack_o), 32'd0);
    end
  end

  // Clock-enable pattern: 0 always on, 1 alternating, 2 random (mostly on).
  initial forever begin
    @(negedge clk);
    case (ce_mode)
      1:       clk_en = ~clk_en;
      2:       clk_en = ($urandom_range(0, 3) != 0);
      default: clk_en = 1'b1;
    endcase
  end

  // Waits at negedges for an event; returns enabled edges elapsed, or -1 after a FAIL.
  task automatic wait_sig(input int sel, input string nm, output int n_en);
    int start;
    int k;
    bit hit;
    start = en_cnt; k = 0; hit = 1'b0; n_en = -1;
    while (!hit && k < BOUND) begin
      @(negedge clk);
      k++;
      case (sel)
        0:       hit = (rdy_o === 1'b1);
        1:       hit = (ack_o === 1'b1);
        2:       hit = (reg_o_valid === 1'b1);
        3:       hit = (timeout_o === 1'b1);
        default: hit = (reg_o_valid === 1'b1) || (timeout_o === 1'b1);
      endcase
    end
    if (hit) n_en = en_cnt - start;
    else begin
      total++; bad++;
      $display("FAIL wait_%s: no event within %0d cycles", nm, BOUND);
    end
  endtask

  // Counts consecutive negedges a strobe stays high, starting from one already seen high.
  task automatic count_high(input int sel, output int cnt);
    bit done;
    bit v;
    cnt = 1; done = 1'b0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      v = (sel == 0) ? (rdy_o === 1'b1) : (reg_o_valid === 1'b1);
      if (v) cnt++;
      else done = 1'b1;
    end
  endtask

  task automatic do_xfer(input logic [15:0] w);
    int n;
    @(negedge clk);
    reg_i = w; req_i = 1'b1;
    wait_sig(0, "rdy", n);
    req_i = 1'b0; conf_i = 1'b1;
    wait_sig(1, "ack", n);
    conf_i = 1'b0;
    wait_sig(2, "valid", n);
  endtask

  initial begin
    int n, st, cnt, mode;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rdy_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_reg", 32'(reg_o), 32'h5A5A);
    check("rst_valid", 32'(reg_o_valid), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    rst = 1'b0;

    // Nominal transfer.
    @(negedge clk);
    reg_i = 16'hA5C3; req_i = 1'b1;
    wait_sig(0, "nom_rdy", n);
    check("nom_rdy_latency", 32'(n), 32'd4);
    req_i = 1'b0; conf_i = 1'b1;
    wait_sig(1, "nom_ack", n);
    check("nom_ack_latency", 32'(n), 32'd5);
    conf_i = 1'b0;
    wait_sig(2, "nom_valid", n);
    check("nom_reg", 32'(reg_o), 32'hA5C3);
    @(negedge clk);
    check("nom_strobe_single", 32'(reg_o_valid), 32'd0);

    // Timeout: request without confirm.
    repeat (3) @(negedge clk);
    req_i = 1'b1;
    wait_sig(0, "tmo_rdy", n);
    req_i = 1'b0;
    count_high(0, cnt);
    check("tmo_rdy_cycles", 32'(cnt), 32'd8);
    check("tmo_strobe", 32'(timeout_o), 32'd1);
    @(negedge clk);
    check("tmo_strobe_single", 32'(timeout_o), 32'd0);
    check("tmo_reg_hold", 32'(reg_o), 32'hA5C3);

    // Data glitch one cycle after conf_s rises.
    repeat (3) @(negedge clk);
    reg_i = 16'h0001; req_i = 1'b1;
    wait_sig(0, "gl_rdy", n);
    req_i = 1'b0; conf_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reg_i = 16'h0002;
    wait_sig(1, "gl_ack", n);
    conf_i = 1'b0;
    wait_sig(2, "gl_valid", n);
    check("glitch_reg", 32'(reg_o), 32'h0002);

    // Short confirm pulse with a glitch: only the stability check holds completion back.
    repeat (3) @(negedge clk);
    reg_i = 16'h0003; req_i = 1'b1;
    wait_sig(0, "gl2_rdy", n);
    req_i = 1'b0; conf_i = 1'b1; st = en_cnt;
    @(negedge clk);
    conf_i = 1'b0;
    repeat (3) @(negedge clk);
    reg_i = 16'h0004;
    wait_sig(2, "gl2_valid", n);
    check("glitch2_latency", 32'(en_cnt - st), 32'd8);
    check("glitch2_reg", 32'(reg_o), 32'h0004);

    // Clock enable toggling.
    ce_mode = 1;
    repeat (2) @(negedge clk);
    reg_i = 16'hFFFF; req_i = 1'b1;
    wait_sig(0, "ce_rdy", n);
    check("ce_rdy_latency", 32'(n), 32'd4);
    req_i = 1'b0; conf_i = 1'b1;
    wait_sig(1, "ce_ack", n);
    check("ce_ack_latency", 32'(n), 32'd5);
    conf_i = 1'b0;
    wait_sig(2, "ce_valid", n);
    check("ce_reg", 32'(reg_o), 32'hFFFF);
    count_high(1, cnt);
    check("ce_valid_span", 32'(cnt), 32'd2);
    ce_mode = 0;

    // Reset in ROUND_WAIT.
    repeat (3) @(negedge clk);
    reg_i = 16'hCAFE; req_i = 1'b1;
    wait_sig(0, "rst_rdy_w", n);
    req_i = 1'b0; conf_i = 1'b1;
    wait_sig(1, "rst_ack_w", n);
    rst = 1'b1; conf_i = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy", 32'(rdy_o), 32'd0);
    check("mid_rst_ack", 32'(ack_o), 32'd0);
    check("mid_rst_reg", 32'(reg_o), 32'h5A5A);
    check("mid_rst_valid", 32'(reg_o_valid), 32'd0);
    rst = 1'b0;
    do_xfer(16'h1234);
    check("post_rst_reg", 32'(reg_o), 32'h1234);

    // Back-to-back: next request raised as the first confirm drops.
    repeat (2) @(negedge clk);
    reg_i = 16'h1111; req_i = 1'b1;
    wait_sig(0, "b2b_rdy1", n);
    req_i = 1'b0; conf_i = 1'b1;
    wait_sig(1, "b2b_ack1", n);
    conf_i = 1'b0; req_i = 1'b1; reg_i = 16'h2222;
    wait_sig(2, "b2b_valid1", n);
    check("b2b_first", 32'(reg_o), 32'h1111);
    wait_sig(0, "b2b_rdy2", n);
    req_i = 1'b0; conf_i = 1'b1;
    wait_sig(1, "b2b_ack2", n);
    conf_i = 1'b0;
    wait_sig(2, "b2b_valid2", n);
    check("b2b_second", 32'(reg_o), 32'h2222);

    // Randomised transfers, glitches, short pulses and stalls under a random clock enable.
    ce_mode = 2;
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      mode = $urandom_range(0, 3);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      reg_i = w[15:0]; req_i = 1'b1;
      wait_sig(0, "rnd_rdy", n);
      req_i = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case (mode)
        0: begin
          conf_i = 1'b1;
          wait_sig(1, "rnd_ack", n);
          conf_i = 1'b0;
          wait_sig(2, "rnd_valid", n);
        end
        1: begin
          conf_i = 1'b1;
          repeat ($urandom_range(0, 5)) @(negedge clk);
          w = $urandom;
          reg_i = w[15:0];
          wait_sig(1, "rnd_gack", n);
          conf_i = 1'b0;
          wait_sig(4, "rnd_gend", n);
        end
        2: begin
          conf_i = 1'b1;
          @(negedge clk);
          conf_i = 1'b0;
          wait_sig(4, "rnd_pend", n);
        end
        default: begin
          wait_sig(3, "rnd_tmo", n);
        end
      endcase
    end
    ce_mode = 0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
